// File: rtl/mem_bit_loader_pkg.sv
// mem_bit_loader_pkg
// Shared types and constants for the bit-serial memory write loader and
// the matching read-side unloader.
//   state_t          : loader FSM state encoding
//   NUM_BANKS, SEL_W : bank count and bank-select width
//   X_*/W_*          : default word/address widths for the x and w banks
package mem_bit_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int NUM_BANKS = 4;
    localparam int SEL_W     = 2;

    localparam int X_WORD_W = 16;
    localparam int X_ADDR_W = 10;
    localparam int W_WORD_W = 16;
    localparam int W_ADDR_W = 20;

endpackage

// File: rtl/mem_bit_loader_bit_ptr.sv
// bit_ptr
// Bit address plus bank counter. The address walks modulo 2^ADDR_W and
// carries into the bank select; a carry out of the last bank sets a sticky
// wrap flag that is cleared on the next load.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load                : take load_sel/load_addr, clear wrapped (wins over advance)
//   advance             : step the pointer by one bit
//   load_sel, load_addr : starting bank and bit address
//   sel, addr           : current bank and bit address
//   wrapped             : sticky, set when the pointer rolls past the last bank
module bit_ptr
    import mem_bit_loader_pkg::*;
#(
    parameter int ADDR_W = X_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [SEL_W-1:0]  load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [SEL_W-1:0]  sel,
    output logic [ADDR_W-1:0] addr,
    output logic              wrapped
);

    logic addr_last;
    logic bank_last;

    assign addr_last = &addr;
    assign bank_last = (sel == SEL_W'(NUM_BANKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= '0;
            addr    <= '0;
            wrapped <= 1'b0;
        end else if (load) begin
            sel     <= load_sel;
            addr    <= load_addr;
            wrapped <= 1'b0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (addr_last) begin
                sel <= sel + SEL_W'(1);
                if (bank_last) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bit_loader.sv
// mem_bit_loader
// Accepts parallel words over valid/ready and writes them LSB first as
// one-bit writes, walking the bit address across banks.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | in_ready high, waiting for the next word
// SHIFT  | one bit written per cycle; last bit may reload back-to-back
// FIN    | done pulse, then back to IDLE
//
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   start, base_sel, base_addr,
//   num_words                       : load request and its parameters
//   in_valid, in_data, in_ready     : word input handshake
//   write_rq, read_rq, write_data,
//   rw_address, sel                 : bit-serial memory write port
//   busy, done, wrapped             : status
module mem_bit_loader
    import mem_bit_loader_pkg::*;
#(
    parameter int WORD_W = X_WORD_W,
    parameter int ADDR_W = X_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  base_sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              write_rq,
    output logic              read_rq,
    output logic              write_data,
    output logic [ADDR_W-1:0] rw_address,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    localparam int BC_W = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  words_left;

    logic last_bit;
    logic more_words;
    logic accept;
    logic start_ok;

    assign last_bit   = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
    assign more_words = (words_left != '0);
    // in_ready is a pure decode of registered state, so it never depends on in_valid.
    assign in_ready   = (state == ST_FETCH) || (last_bit && more_words);
    assign accept     = in_valid && in_ready;
    assign start_ok   = start && (state == ST_IDLE);

    assign write_data = shreg[0];
    assign read_rq    = 1'b0;

    bit_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok),
        .advance   (state == ST_SHIFT),
        .load_sel  (base_sel),
        .load_addr (base_addr),
        .sel       (sel),
        .addr      (rw_address),
        .wrapped   (wrapped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            write_rq   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        words_left <= num_words;
                        if (num_words == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (accept) begin
                        shreg      <= in_data;
                        bit_cnt    <= '0;
                        words_left <= words_left - CNT_W'(1);
                        write_rq   <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + BC_W'(1);
                    if (last_bit) begin
                        if (accept) begin
                            // Reload in the last-bit cycle: next word starts with no bubble.
                            shreg      <= in_data;
                            bit_cnt    <= '0;
                            words_left <= words_left - CNT_W'(1);
                        end else if (more_words) begin
                            write_rq <= 1'b0;
                            state    <= ST_FETCH;
                        end else begin
                            write_rq <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bit_loader.sv
module tb_mem_bit_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  base_sel;
    logic [9:0]  base_addr;
    logic [15:0] num_words;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        write_rq;
    logic        read_rq;
    logic        write_data;
    logic [9:0]  rw_address;
    logic [1:0]  sel;
    logic        busy;
    logic        done;
    logic        wrapped;

    int tests = 0;
    int fails = 0;

    mem_bit_loader #(
        .WORD_W (16),
        .ADDR_W (10),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_sel   (base_sel),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .write_rq   (write_rq),
        .read_rq    (read_rq),
        .write_data (write_data),
        .rw_address (rw_address),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    // Cycle numbers are relative to the cycle in which start is high (cycle 0).
    typedef struct {
        int               bsel;
        int               baddr;
        int               nw;
        logic [2:0][15:0] words;
        int               vf1;            // earliest cycle in_valid offered for word 1
        int               exp_wr;         // number of write_rq cycles
        int               exp_done;       // cycle of the done pulse
        int               exp_last_wr;    // cycle of the final write_rq
        int               exp_ready_n;    // cycles with in_ready high
        int               exp_ready_last; // last cycle in_ready was high
        int               exp_wrap;       // wrapped after done
        int               exp_busy;       // busy ever seen high
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_load(input int idx);
        vec_t        v;
        int          nwr, widx, ready_n, ready_last, done_cyc, last_wr, bad, vfrom;
        logic        busy_seen, busy_at_done, exp_bit;
        logic [1:0]  m_sel;
        logic [9:0]  m_addr;
        logic        m_wrap;
        v = vecs[idx];
        @(negedge clk);
        start     = 1'b1;
        base_sel  = 2'(v.bsel);
        base_addr = 10'(v.baddr);
        num_words = 16'(v.nw);
        in_valid  = 1'b0;
        m_sel = 2'(v.bsel); m_addr = 10'(v.baddr); m_wrap = 1'b0;
        nwr = 0; widx = 0; ready_n = 0; ready_last = 0; done_cyc = -1;
        last_wr = 0; bad = 0; busy_seen = 1'b0; busy_at_done = 1'b0;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (in_ready) begin
                ready_n++;
                ready_last = cyc;
            end
            if (write_rq) begin
                exp_bit = v.words[nwr / 16][nwr % 16];
                if (sel !== m_sel || rw_address !== m_addr || write_data !== exp_bit
                    || wrapped !== m_wrap) begin
                    bad++;
                end
                nwr++;
                last_wr = cyc;
                if (m_addr == 10'h3FF) begin
                    if (m_sel == 2'd3) m_wrap = 1'b1;
                    m_sel = m_sel + 2'd1;
                end
                m_addr = m_addr + 10'd1;
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            in_valid = 1'b0;
            vfrom = (widx == 1) ? v.vf1 : 0;
            if (done_cyc < 0 && widx < v.nw && cyc >= vfrom) begin
                in_valid = 1'b1;
                in_data  = v.words[widx];
                if (in_ready) widx++;
            end
        end
        in_valid = 1'b0;
        check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d write_count", idx), nwr, v.exp_wr);
        check($sformatf("v%0d bad_writes", idx), bad, 0);
        check($sformatf("v%0d last_write_cycle", idx), last_wr, v.exp_last_wr);
        check($sformatf("v%0d ready_count", idx), ready_n, v.exp_ready_n);
        check($sformatf("v%0d ready_last", idx), ready_last, v.exp_ready_last);
        check($sformatf("v%0d busy_seen", idx), busy_seen, v.exp_busy);
        check($sformatf("v%0d busy_at_done", idx), busy_at_done, 0);
        check($sformatf("v%0d wrapped_end", idx), wrapped, v.exp_wrap);
        check($sformatf("v%0d read_rq", idx), read_rq, 0);
    endtask

    int n_done, n_wr;

    initial begin
        //                bsel baddr nw  words                                  vf1 wr done lastwr rdy_n rdy_last wrap busy
        vecs[0] = '{0,    0,    1, {16'h0000, 16'h0000, 16'hA5C3},  0, 16, 18, 17, 1,  1, 0, 1};
        vecs[1] = '{0,    0,    3, {16'h0F0F, 16'hBEEF, 16'h1234},  0, 48, 50, 49, 3, 33, 0, 1};
        vecs[2] = '{1,    1020, 1, {16'h0000, 16'h0000, 16'hFFFF},  0, 16, 18, 17, 1,  1, 0, 1};
        vecs[3] = '{3,    1016, 1, {16'h0000, 16'h0000, 16'h3C5A},  0, 16, 18, 17, 1,  1, 1, 1};
        vecs[4] = '{2,    500,  0, {16'h0000, 16'h0000, 16'h0000},  0,  0,  1,  0, 0,  0, 0, 0};
        vecs[5] = '{0,    200,  2, {16'h0000, 16'h7E57, 16'hC001}, 22, 32, 39, 38, 7, 22, 0, 1};

        rst = 1'b1; start = 1'b0; base_sel = '0; base_addr = '0; num_words = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {in_ready, write_rq, read_rq, write_data, rw_address, sel, busy, done, wrapped}, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_load(i);
        end

        // Start while busy is ignored, then reset in the middle of the second word.
        @(negedge clk);
        start = 1'b1; base_sel = 2'd2; base_addr = 10'd100; num_words = 16'd2;
        @(negedge clk);                       // cycle 1: FETCH
        start = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
        @(negedge clk);                       // cycle 2
        in_valid = 1'b0;
        repeat (8) @(negedge clk);            // cycle 10
        start = 1'b1; num_words = 16'd0;
        @(negedge clk);                       // cycle 11
        start = 1'b0;
        check("busy_start_no_done", done, 0);
        check("busy_start_still_writing", write_rq, 1);
        repeat (11) @(negedge clk);           // cycle 22: FETCH after gap
        check("gap_write_low", write_rq, 0);
        in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);                       // cycle 23: bit0 of word 2
        in_valid = 1'b0;
        check("second_word_bit0", {write_rq, write_data, sel, rw_address}, {1'b1, 1'b0, 2'd2, 10'd116});
        repeat (4) @(negedge clk);            // cycle 27
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs",
              {in_ready, write_rq, read_rq, write_data, rw_address, sel, busy, done, wrapped}, 0);
        rst = 1'b0;
        n_done = 0; n_wr = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
            if (write_rq) n_wr++;
        end
        check("after_reset_no_done", n_done, 0);
        check("after_reset_no_write", n_wr, 0);

        run_load(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bit_loader.md
# mem_bit_loader

Upstream write-side feeder for the bit-serial memory system. It accepts parallel words over a valid/ready handshake and serializes each word, LSB first, into one-bit writes. For every bit it drives write_rq, write_data, a bit address and a two-bit bank select. The bank select feeds the 1-to-4 bank demultiplexer, so a load walks the address space and rolls from one bank into the next without host intervention.

## Interface
Parameters:
- WORD_W, 16, bits per input word (2..32)
- ADDR_W, 10, bit-address width per bank (10 for x banks, 20 for w banks)
- CNT_W, 16, width of the word-count field

Ports:
- clk  input  1  rising-edge clock (only clock)
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; ignored unless idle
- base_sel  input  2  starting bank, sampled with start
- base_addr  input  ADDR_W  starting bit address, sampled with start
- num_words  input  CNT_W  words to load, sampled with start
- in_valid  input  1  in_data valid
- in_data  input  WORD_W  word to serialize
- in_ready  output  1  loader accepts in_data this cycle
- write_rq  output  1  one-bit write strobe to memory
- read_rq  output  1  constant 0 (loader never reads)
- write_data  output  1  bit being written
- rw_address  output  ADDR_W  bit address within the bank
- sel  output  2  bank select
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the last bit has been issued
- wrapped  output  1  sticky; set when the address rolls past bank 3, cleared by the next accepted start

## Operation
- FSM states are IDLE, FETCH, SHIFT and FIN.
- IDLE: start=1 latches base_sel, base_addr and num_words.
  - If num_words=0, go to FIN.
  - Otherwise go to FETCH and set busy.
- FETCH: in_ready=1. On in_valid&in_ready:
  - load the shift register with in_data and set the bit counter to 0;
  - decrement the remaining-word count;
  - go to SHIFT.
- SHIFT: write_rq=1, write_data=shreg[0], with rw_address/sel equal to the current pointer. Each cycle:
  - shift right;
  - increment the bit counter;
  - advance the pointer.
- Pointer advance:
  - rw_address+1, modulo 2^ADDR_W.
  - When rw_address is all-ones, it becomes 0 and sel increments.
  - When sel=3 rolls to 0, wrapped is set.
- On the last bit (bit counter = WORD_W-1):
  - If words remain: in_ready=1 in that same cycle. A handshake reloads the shift register and stays in SHIFT, so the loader runs back-to-back with no bubble. With no handshake, go to FETCH.
  - If no words remain: go to FIN.
- FIN: done=1 for one cycle, busy falls, go to IDLE.
- start while not IDLE has no effect. in_valid outside in_ready windows is ignored; no data is dropped, because acceptance only happens under handshake.
- read_rq is tied to 0, so the memory's write-only condition always holds.

## Timing
- Reset: state IDLE; all outputs 0; pointer, counters and shift register 0. Reset mid-load aborts immediately.
  - Bits already written stay in memory.
  - No done pulse is produced.
- Word handshake at cycle N: bit0 is on the write outputs at N+1 and bit WORD_W-1 at N+WORD_W.
- Back-to-back stream: one bit per cycle. K words take K*WORD_W write cycles plus 1 FETCH cycle.
- done asserts the cycle after the final write_rq.
- start to first possible handshake: 1 cycle (FETCH begins the cycle after start).
- num_words=0: done is the cycle after start, busy stays 0, and write_rq never asserts.
- write_rq, write_data, rw_address and sel all change only on clk rising edges and are registered. They are mutually consistent in every cycle.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE/FETCH/SHIFT/FIN);
  - the bank count constant 4 and the bank select width 2;
  - default WORD_W/ADDR_W constants for the x and w configurations.
- Sub-module bit_ptr: ADDR_W address plus 2-bit bank counter with load, advance and a wrap flag. It is reused by the matching read-side unloader.

## Test plan
- WORD_W=16, ADDR_W=10, base_sel=0, base_addr=0, num_words=1, in_data=16'hA5C3:
  - 16 write_rq cycles at addresses 0..15;
  - write_data sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
  - done one cycle after the last write.
- num_words=3 with in_valid held high: 48 consecutive write_rq cycles, no gaps, addresses 0..47, in_ready pulses exactly at cycles 1, 17 and 33 after start.
- base_sel=1, base_addr=1020, num_words=1, data 16'hFFFF:
  - writes at bank1 addresses 1020..1023, then bank2 addresses 0..11;
  - wrapped stays 0.
- base_sel=3, base_addr=1016, num_words=1: writes at bank3 addresses 1016..1023, then bank0 addresses 0..7; wrapped=1 from the rollover cycle until the next start.
- num_words=0: done at start+1, no write_rq, busy never 1.
- num_words=2, throttled in_valid (second word 5 cycles late): write_rq stays low during the gap. Then rst asserted mid-second-word: all outputs 0 next cycle, no done, and a fresh start is accepted afterward.
